// File: rtl/piggy_pkg.sv
// Shared constants, scheduler state encoding and snapshot layout for the piggy-bank report path.
package piggy_pkg;
  localparam int FRAME_LEN = 18;
  localparam int IDX_W     = 5;
  localparam int NUM_CH    = 4;
  localparam int ASCII_W   = 24;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_SEP = 8'h2C;

  // Byte positions inside one 24-bit ASCII count field
  localparam int HUND_LSB = 16;
  localparam int TENS_LSB = 8;
  localparam int ONES_LSB = 0;

  typedef enum logic [2:0] {IDLE, SNAP, SEND, WAIT, GAP} sched_state_e;

  typedef logic [NUM_CH-1:0][ASCII_W-1:0] snap_t;

  function automatic logic [7:0] ascii_digit(input logic [ASCII_W-1:0] a, input logic [1:0] pos);
    case (pos)
      2'd0:    return a[HUND_LSB +: 8];
      2'd1:    return a[TENS_LSB +: 8];
      default: return a[ONES_LSB +: 8];
    endcase
  endfunction
endpackage

// File: rtl/piggy_frame_mux.sv
// Frame layout: maps a byte index plus the count snapshot to the byte on the wire.
module piggy_frame_mux
  import piggy_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = 8'h50
) (
  input  logic [IDX_W-1:0] idx_i,
  input  snap_t            snap_i,
  output logic [7:0]       byte_o
);
  logic [IDX_W-1:0] off;
  logic [1:0]       grp;
  logic [1:0]       pos;

  // Indices 1..15 form four groups of "hundreds, tens, ones, separator";
  // the last group's separator slot is the CR at index 16.
  always_comb begin
    off    = idx_i - 5'd1;
    grp    = off[3:2];
    pos    = off[1:0];
    byte_o = 8'h00;
    if (idx_i == 5'd0)       byte_o = HDR_BYTE;
    else if (idx_i == 5'd16) byte_o = ASCII_CR;
    else if (idx_i == 5'd17) byte_o = ASCII_LF;
    else if (idx_i < 5'd16)  byte_o = (pos == 2'd3) ? ASCII_SEP : ascii_digit(snap_i[grp], pos);
  end
endmodule

// File: rtl/piggy_report_sched.sv
// Coalesces count-change / print requests into 18-byte report frames fed byte-by-byte to the UART TX.
module piggy_report_sched
  import piggy_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE       = 8'h50,
  parameter int         GAP_CYCLES     = 1000,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  change_in,
  input  logic        print_req,
  input  logic [23:0] ascii0,
  input  logic [23:0] ascii1,
  input  logic [23:0] ascii2,
  input  logic [23:0] ascii3,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  sched_state_e     state_q;
  logic             pending_q;
  logic [IDX_W-1:0] idx_q;
  logic [GAP_W-1:0] gap_q;
  logic [TO_W-1:0]  to_q;
  snap_t            snap_q;
  snap_t            snap_d;
  logic             tx_dv_q, busy_q, frame_done_q, timeout_err_q;
  logic [7:0]       tx_byte_q;
  logic [7:0]       frame_byte;
  logic             req;

  assign req    = (|change_in) | print_req;
  assign snap_d = {ascii3, ascii2, ascii1, ascii0};

  piggy_frame_mux #(.HDR_BYTE(HDR_BYTE)) u_mux (
    .idx_i  (idx_q),
    .snap_i (snap_q),
    .byte_o (frame_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      idx_q         <= '0;
      gap_q         <= '0;
      to_q          <= '0;
      snap_q        <= '0;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= 8'h00;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tx_dv_q      <= 1'b0;
      frame_done_q <= 1'b0;
      // A request landing in the SNAP cycle must survive the clear
      pending_q    <= (state_q == SNAP) ? req : (pending_q | req);
      case (state_q)
        IDLE: if (pending_q) begin
          state_q <= SNAP;
          busy_q  <= 1'b1;
        end
        SNAP: begin
          snap_q  <= snap_d;
          idx_q   <= '0;
          state_q <= SEND;
        end
        SEND: if (!tx_active) begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= frame_byte;
          to_q      <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (idx_q == IDX_LAST) begin
              frame_done_q  <= 1'b1;
              timeout_err_q <= 1'b0;
              gap_q         <= '0;
              state_q       <= GAP;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= SEND;
            end
          end else if (to_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            gap_q         <= '0;
            state_q       <= GAP;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_dv       = tx_dv_q;
  assign tx_byte     = tx_byte_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_piggy_report_sched.sv
// Scoreboard bench: stimulus pushes expected frame bytes, a monitor pops them on every tx_dv.
module tb_piggy_report_sched;
  localparam int GAP = 20;
  localparam int TO  = 50;

  logic        clk, reset_n;
  logic [3:0]  change_in;
  logic        print_req;
  logic [23:0] ascii0, ascii1, ascii2, ascii3;
  logic        tx_active, tx_done;
  logic        tx_dv, busy, frame_done, timeout_err;
  logic [7:0]  tx_byte;

  logic        force_active, uart_busy, uart_ok, uart_rand;
  int          n_tests, n_fail, bytes_seen, fd_cnt, cyc, last_fd_cyc, last_dv_cyc;
  logic        prev_dv;
  int          cnt [4];
  logic [7:0]  exp_q [$];

  assign tx_active = force_active | uart_busy;

  piggy_report_sched #(.HDR_BYTE(8'h50), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .change_in(change_in), .print_req(print_req),
    .ascii0(ascii0), .ascii1(ascii1), .ascii2(ascii2), .ascii3(ascii3),
    .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] to_ascii(input int v);
    return {8'(48 + v / 100), 8'(48 + (v / 10) % 10), 8'(48 + v % 10)};
  endfunction

  task automatic set_counts(input int a, input int b, input int c, input int d);
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
    ascii0 = to_ascii(a); ascii1 = to_ascii(b); ascii2 = to_ascii(c); ascii3 = to_ascii(d);
  endtask

  // Reference frame is the printed report text, independent of any byte indexing
  task automatic push_frame();
    string s;
    s = $sformatf("P%03d,%03d,%03d,%03d", cnt[0], cnt[1], cnt[2], cnt[3]);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse(input logic [3:0] ch, input logic pr);
    @(negedge clk); change_in = ch; print_req = pr;
    @(negedge clk); change_in = 4'h0; print_req = 1'b0;
  endtask

  task automatic wait_fd(input string nm);
    int k = 0;
    while (!frame_done && k < 2000) begin @(negedge clk); k++; end
    chk(nm, frame_done, 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 2000) begin @(negedge clk); k++; end
    chk(nm, busy, 1'b0);
  endtask

  task automatic wait_bytes(input int n, input string nm);
    int k = 0;
    while (bytes_seen < n && k < 1000) begin @(negedge clk); k++; end
    chk(nm, 32'(bytes_seen >= n), 32'd1);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compare every presented byte against the scoreboard head
  always @(negedge clk) begin
    if (reset_n) begin
      if (tx_dv) begin
        bytes_seen++;
        chk("dv_single_cycle", prev_dv, 1'b0);
        if (exp_q.size() == 0) chk("unexpected_byte", tx_byte, 32'hFFFF_FFFF);
        else chk("frame_byte", tx_byte, exp_q.pop_front());
        if (last_fd_cyc > last_dv_cyc) chk("inter_frame_gap", 32'(cyc - last_fd_cyc >= GAP), 32'd1);
        last_dv_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        last_fd_cyc = cyc;
      end
      prev_dv = tx_dv;
    end else begin
      prev_dv = 1'b0;
    end
  end

  // UART byte TX model: busy from tx_dv until a one-cycle tx_done after a latency
  initial begin
    int lat;
    uart_busy = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && tx_dv && uart_ok) begin
        uart_busy = 1'b1;
        lat = uart_rand ? int'($urandom_range(1, 12)) : 10;
        repeat (lat - 1) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done   = 1'b0;
        uart_busy = 1'b0;
      end
    end
  end

  initial begin
    int base, dvs, k;
    n_tests = 0; n_fail = 0; bytes_seen = 0; fd_cnt = 0; cyc = 0;
    last_fd_cyc = -1; last_dv_cyc = -1; prev_dv = 1'b0;
    reset_n = 1'b0; change_in = 4'h0; print_req = 1'b0;
    force_active = 1'b0; uart_ok = 1'b1; uart_rand = 1'b0;
    set_counts(10, 5, 2, 1);
    repeat (3) @(negedge clk);
    chk("rst_tx_dv", tx_dv, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame and busy release exactly GAP cycles after frame_done
    push_frame();
    pulse(4'h0, 1'b1);
    wait_fd("t1_frame_done");
    repeat (GAP - 1) @(negedge clk);
    chk("t1_busy_in_gap", busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_after_gap", busy, 1'b0);
    chk("t1_fd_count", fd_cnt, 1);
    chk("t1_queue_empty", exp_q.size(), 0);

    // Several change pulses before SNAP coalesce into one frame
    set_counts(123, 456, 789, 0);
    push_frame();
    @(negedge clk); change_in = 4'b0101;
    @(negedge clk); change_in = 4'b1000;
    @(negedge clk); change_in = 4'b0000;
    wait_fd("t2_frame_done");
    wait_idle("t2_idle");
    repeat (30) @(negedge clk);
    chk("t2_fd_count", fd_cnt, 2);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Mid-frame count change: current frame keeps the snapshot, one follow-up frame
    set_counts(10, 5, 2, 1);
    push_frame();
    base = bytes_seen;
    pulse(4'h0, 1'b1);
    wait_bytes(base + 6, "t3_reach_byte5");
    set_counts(20, 5, 2, 1);
    push_frame();
    pulse(4'h1, 1'b0);
    wait_fd("t3_first_frame");
    @(negedge clk);
    wait_fd("t3_followup_frame");
    wait_idle("t3_idle");
    repeat (30) @(negedge clk);
    chk("t3_fd_count", fd_cnt, 4);
    chk("t3_queue_empty", exp_q.size(), 0);

    // Byte timeout: no tx_done ever, abort after TO cycles in WAIT
    uart_ok = 1'b0;
    exp_q.push_back(8'h50);
    pulse(4'h0, 1'b1);
    k = 0;
    while (!tx_dv && k < 20) begin @(negedge clk); k++; end
    chk("t4_first_dv", tx_dv, 1'b1);
    repeat (TO - 1) @(negedge clk);
    chk("t4_err_before", timeout_err, 1'b0);
    @(negedge clk);
    chk("t4_err_set", timeout_err, 1'b1);
    wait_idle("t4_idle");
    chk("t4_no_frame_done", fd_cnt, 4);
    uart_ok = 1'b1;
    push_frame();
    pulse(4'h0, 1'b1);
    k = 0;
    while (!tx_dv && k < 20) begin @(negedge clk); k++; end
    chk("t4_err_held", timeout_err, 1'b1);
    wait_fd("t4_recover_frame");
    chk("t4_err_cleared", timeout_err, 1'b0);
    wait_idle("t4_idle2");

    // tx_active held high: tx_dv withheld, then issued once
    push_frame();
    @(negedge clk); print_req = 1'b1; force_active = 1'b1;
    @(negedge clk); print_req = 1'b0;
    dvs = 0;
    repeat (20) begin @(negedge clk); if (tx_dv) dvs++; end
    chk("t5_dv_withheld", dvs, 0);
    force_active = 1'b0;
    k = 0;
    while (!tx_dv && k < 5) begin @(negedge clk); k++; end
    chk("t5_dv_released", tx_dv, 1'b1);
    @(negedge clk);
    chk("t5_dv_one_cycle", tx_dv, 1'b0);
    wait_fd("t5_frame_done");
    wait_idle("t5_idle");

    // Asynchronous reset in the middle of a frame
    push_frame();
    base = bytes_seen;
    pulse(4'h0, 1'b1);
    wait_bytes(base + 10, "t6_reach_byte9");
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_tx_dv", tx_dv, 1'b0);
    chk("t6_rst_tx_byte", tx_byte, 8'h00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_frame_done", frame_done, 1'b0);
    chk("t6_rst_timeout_err", timeout_err, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    base = bytes_seen;
    repeat (60) @(negedge clk);
    chk("t6_no_dv_after_reset", bytes_seen, base);
    chk("t6_idle_after_reset", busy, 1'b0);
    base = fd_cnt;
    push_frame();
    pulse(4'h0, 1'b1);
    wait_fd("t6_new_frame");
    wait_idle("t6_idle");

    // Randomized counts, request mix and UART latency
    uart_rand = 1'b1;
    for (int it = 0; it < 8; it++) begin
      logic [3:0] ch;
      logic       pr;
      set_counts($urandom_range(0, 999), $urandom_range(0, 999),
                 $urandom_range(0, 999), $urandom_range(0, 999));
      push_frame();
      pr = 1'($urandom_range(0, 1));
      ch = 4'($urandom_range(0, 15));
      if (!pr && ch == 4'h0) ch = 4'h2;
      base = fd_cnt;
      @(negedge clk); change_in = ch; print_req = pr;
      @(negedge clk); change_in = 4'($urandom_range(0, 15)); print_req = 1'b0;
      @(negedge clk); change_in = 4'h0;
      wait_fd("rnd_frame_done");
      wait_idle("rnd_idle");
      repeat (10) @(negedge clk);
      chk("rnd_one_frame", fd_cnt, base + 1);
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
